psum_accum_buffer: RTL
======================

Name: psum_accum_buffer

Overview:
- Column-bottom output stage of the systolic array; consumes the registered `sum_out` stream of the last PE in a column.
- Accumulates partial sums across weight tiles into an addressed on-chip buffer, widening from `SUM_BITWIDTH` to `ACC_BITWIDTH`.
- On request, drains the finished accumulators in address order over a valid/ready stream toward the output/post-processing unit.

Parameters:
- `SUM_BITWIDTH`, 16: width of incoming PE partial sum (signed two's complement).
- `ACC_BITWIDTH`, 32: accumulator entry width; must be ≥ `SUM_BITWIDTH`.
- `ADDR_BITWIDTH`, 6: buffer address width; `DEPTH = 2**ADDR_BITWIDTH` entries.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `sum_in_valid`, input, 1: partial sum present this cycle.
- `sum_in`, input, `SUM_BITWIDTH`: partial sum from the column's last PE.
- `sum_in_addr`, input, `ADDR_BITWIDTH`: target accumulator entry.
- `sum_in_first`, input, 1: 1 = overwrite entry (first tile); 0 = accumulate.
- `in_ready`, output, 1: block is accepting sums (state IDLE).
- `drain_start`, input, 1: begin draining entries 0..`drain_len`-1.
- `drain_len`, input, `ADDR_BITWIDTH`: number of entries to drain; 0 means `DEPTH`.
- `out_valid`, output, 1: drained word valid.
- `out_ready`, input, 1: consumer accepts word.
- `out_data`, output, `ACC_BITWIDTH`: drained accumulator value.
- `out_last`, output, 1: current word is the final entry of the drain.
- `busy`, output, 1: state ≠ IDLE, or accumulate pipeline non-empty.
- `err_drop`, output, 1: sticky; a sum arrived while `in_ready` = 0.
- `accum_overflow`, output, 1: sticky overflow flag (see Optional Feature).

Behaviour:
- **Reset** (`reset` = 0, async):
  - State returns to IDLE; pipeline valids and drain counters are cleared.
  - `out_valid`, `out_last`, `err_drop` and `accum_overflow` reset to 0; `out_data` resets to 0.
  - `in_ready` is 1 after reset; `busy` is 0.
  - Buffer contents are NOT reset, so the first write to each entry must use `sum_in_first` = 1.
  - A reset mid-drain or mid-accumulate aborts the operation immediately; no partial handshake completes.
- **Accumulate pipeline** (2 stages):
  - S1 registers `{addr, first, sign-extended sum}` and issues a synchronous read of `mem[addr]`.
  - S2 computes `new = first ? sum_ext : rd + sum_ext` and writes `mem[addr]` at the end of S2.
  - A sum accepted at edge t is visible in memory after edge t+2.
- **Hazard bypass:**
  - If S1 and S2 hold the same address in the same cycle, the S1 read data is replaced by the S2 write data.
  - Back-to-back sums to one address must therefore accumulate exactly; no stall is permitted, because the PE column cannot be stalled.
- **Sum acceptance:**
  - A sum is accepted only when `sum_in_valid` && `in_ready`.
  - `sum_in_valid` with `in_ready` = 0 drops the sum and sets `err_drop`; it stays set until reset.
- **FSM states:** IDLE, FLUSH, DRAIN.
- **IDLE:**
  - `in_ready` = 1.
  - `drain_start` moves to FLUSH and latches `drain_len`.
  - A sum arriving in the same cycle as `drain_start` is accepted and included in the drain.
- **FLUSH:**
  - `in_ready` = 0.
  - Wait until both pipeline stages are empty (at most 2 cycles), then go to DRAIN with read pointer 0.
- **DRAIN:**
  - The word for entry k is presented with `out_valid` = 1.
  - `out_data` and `out_last` stay stable while `out_valid` && !`out_ready`.
  - The pointer advances on each handshake.
  - With `out_ready` held at 1, sustained throughput is 1 word/cycle after a first-word latency of ≤2 cycles from DRAIN entry.
  - `out_last` = 1 on entry `len`-1. A handshake on the last word returns the FSM to IDLE, and `out_valid` falls the next cycle.
  - `drain_start` is ignored outside IDLE.
  - `drain_len` = 0 drains all `DEPTH` entries, ending with the pointer at `DEPTH`-1 and no wrap.
- **Arithmetic:**
  - `sum_in` is sign-extended to `ACC_BITWIDTH`.
  - Adds are signed, at `ACC_BITWIDTH` width.
  - Overflow handling is per Optional Feature.

Optional Feature:
- Macro: `PSUM_ACC_SAT_EN`.
- **Defined:**
  - The S2 add saturates to the signed `ACC_BITWIDTH` max/min.
  - Any saturation event sets `accum_overflow`, which stays set until reset.
- **Undefined:**
  - The add wraps modulo 2^`ACC_BITWIDTH`.
  - `accum_overflow` is tied to 0.

Test Plan:
1. Reset release, then a sum to addr 3 with first=1, `sum_in`=16'sd100, followed by drain_len=4 → drain outputs entry 3 = 32'sd100; `out_last` on the 4th word; `in_ready` = 0 during FLUSH/DRAIN, then 1.
2. Back-to-back sums to addr 5: first=1 (+7), then −3, then +10 on consecutive cycles → entry 5 drains as 14, proving the S1/S2 bypass.
3. Drain of 3 words with `out_ready` toggling 1,0,0,1,0,1 → exactly 3 handshakes; `out_data` stable during stalls; `out_valid` falls the cycle after the last handshake.
4. `sum_in_valid` asserted during DRAIN → sum dropped, `err_drop` = 1 and it persists into IDLE; memory unchanged.
5. With `PSUM_ACC_SAT_EN` and `ACC_BITWIDTH`=16: entry starts at 16'sh7FF0, add +16'sh0020 → result 16'sh7FFF and `accum_overflow` = 1. Without the macro → 16'sh8010 and flag 0.
6. Assert `reset` low mid-drain after 2 of 8 words → `out_valid` = 0 asynchronously, state IDLE, `in_ready` = 1; a new drain_start with drain_len=0 then streams 64 words.

Source files
------------

// File: rtl/psum_accum_buffer.sv
// Purpose : column-bottom partial-sum accumulator; widens PE sums into an addressed buffer and drains it in address order.
// Latency : a sum accepted at edge t is in memory after edge t+2; drain streams 1 word/cycle, first word 1 cycle after DRAIN entry.
// Backpr. : sums cannot be stalled (dropped + err_drop when in_ready=0); drain output holds data/last while out_ready=0.
//
// Ports:
//   clk, reset (async, active-low)
//   sum_in_valid/sum_in/sum_in_addr/sum_in_first : partial-sum input stream, in_ready = accepting (IDLE)
//   drain_start/drain_len (0 = full depth)        : drain request, honoured in IDLE only
//   out_valid/out_ready/out_data/out_last         : drained accumulator stream
//   busy, err_drop (sticky), accum_overflow (sticky)
// Optional feature macro: PSUM_ACC_SAT_EN -- saturating accumulate with sticky accum_overflow;
//   when undefined the accumulate wraps and accum_overflow is tied low.

module psum_accum_buffer #(
    parameter int SUM_BITWIDTH  = 16,
    parameter int ACC_BITWIDTH  = 32,
    parameter int ADDR_BITWIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sum_in_valid,
    input  logic [SUM_BITWIDTH-1:0]  sum_in,
    input  logic [ADDR_BITWIDTH-1:0] sum_in_addr,
    input  logic                     sum_in_first,
    output logic                     in_ready,
    input  logic                     drain_start,
    input  logic [ADDR_BITWIDTH-1:0] drain_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_BITWIDTH-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err_drop,
    output logic                     accum_overflow
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ACC_BITWIDTH-1:0] r_mem [DEPTH];

    // accumulate pipeline
    logic                     r_s1_vld;
    logic [ADDR_BITWIDTH-1:0] r_s1_addr;
    logic                     r_s1_first;
    logic [ACC_BITWIDTH-1:0]  r_s1_sum;
    logic [ACC_BITWIDTH-1:0]  r_s1_rd;
    logic                     r_s2_vld;
    logic [ADDR_BITWIDTH-1:0] r_s2_addr;
    logic                     r_s2_first;
    logic [ACC_BITWIDTH-1:0]  r_s2_sum;
    logic [ACC_BITWIDTH-1:0]  r_s2_rd;

    // drain path
    logic [ADDR_BITWIDTH-1:0] r_len_m1;
    logic [ADDR_BITWIDTH-1:0] r_ptr;
    logic                     r_out_vld;
    logic [ACC_BITWIDTH-1:0]  r_out_dat;
    logic                     r_out_last;
    logic                     r_err_drop;

    logic                     w_accept;
    logic [ACC_BITWIDTH-1:0]  w_sum_ext;
    logic [ACC_BITWIDTH-1:0]  w_add;
    logic [ACC_BITWIDTH-1:0]  w_add_res;
    logic [ACC_BITWIDTH-1:0]  w_s2_new;
    logic [ACC_BITWIDTH-1:0]  w_s1_rd;
    logic [ACC_BITWIDTH-1:0]  w_mem_rd;
    logic [ADDR_BITWIDTH-1:0] w_ptr_nxt;
    logic [ADDR_BITWIDTH-1:0] w_rd_idx;
    logic [ACC_BITWIDTH-1:0]  w_rd_dat;
    logic                     w_hs;

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = sum_in_valid & in_ready;
    assign w_sum_ext = ACC_BITWIDTH'($signed(sum_in));

    assign w_add = r_s2_rd + r_s2_sum;

`ifdef PSUM_ACC_SAT_EN
    localparam logic [ACC_BITWIDTH-1:0] ACC_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
    localparam logic [ACC_BITWIDTH-1:0] ACC_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};
    logic w_add_ovf;
    logic w_sat_evt;
    logic r_ovf;

    // Signed overflow: operands share a sign and the result sign differs.
    assign w_add_ovf = (r_s2_rd[ACC_BITWIDTH-1] == r_s2_sum[ACC_BITWIDTH-1]) &&
                       (w_add[ACC_BITWIDTH-1] != r_s2_rd[ACC_BITWIDTH-1]);
    assign w_add_res = w_add_ovf ? (r_s2_rd[ACC_BITWIDTH-1] ? ACC_MIN : ACC_MAX) : w_add;
    assign w_sat_evt = r_s2_vld & ~r_s2_first & w_add_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_sat_evt) begin
            r_ovf <= 1'b1;
        end
    end

    assign accum_overflow = r_ovf;
`else
    assign w_add_res      = w_add;
    assign accum_overflow = 1'b0;
`endif

    assign w_s2_new = r_s2_first ? r_s2_sum : w_add_res;

    // S2 is one access ahead of S1: its result has not reached memory yet.
    assign w_s1_rd = (r_s2_vld && (r_s2_addr == r_s1_addr)) ? w_s2_new : r_s1_rd;

    // The read issued at the same edge S2 writes must see that write (write-first).
    assign w_mem_rd = (r_s2_vld && (r_s2_addr == sum_in_addr)) ? w_s2_new : r_mem[sum_in_addr];

    // Buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (r_s2_vld) begin
            r_mem[r_s2_addr] <= w_s2_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_first <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_rd    <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_first <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_rd    <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_addr  <= sum_in_addr;
                r_s1_first <= sum_in_first;
                r_s1_sum   <= w_sum_ext;
                r_s1_rd    <= w_mem_rd;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_addr  <= r_s1_addr;
                r_s2_first <= r_s1_first;
                r_s2_sum   <= r_s1_sum;
                r_s2_rd    <= w_s1_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_drop <= 1'b0;
        end else if (sum_in_valid && !in_ready) begin
            r_err_drop <= 1'b1;
        end
    end

    // FSM
    assign w_hs = r_out_vld & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (drain_start) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!r_s1_vld && !r_s2_vld) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_hs && r_out_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // While a word is held, look ahead to the next entry so a handshake can
    // reload the output register without a bubble.
    assign w_ptr_nxt = r_ptr + 1'b1;
    assign w_rd_idx  = r_out_vld ? w_ptr_nxt : r_ptr;
    assign w_rd_dat  = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_m1   <= '0;
            r_ptr      <= '0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_last <= 1'b0;
        end else begin
            // drain_len of 0 becomes all-ones here, i.e. the full depth.
            if ((r_state == ST_IDLE) && drain_start) begin
                r_len_m1 <= drain_len - 1'b1;
            end
            if (r_state == ST_FLUSH) begin
                r_ptr      <= '0;
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end else if (r_state == ST_DRAIN) begin
                if (!r_out_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_dat  <= w_rd_dat;
                    r_out_last <= (r_ptr == r_len_m1);
                end else if (out_ready) begin
                    if (r_out_last) begin
                        r_out_vld  <= 1'b0;
                        r_out_last <= 1'b0;
                    end else begin
                        r_ptr      <= w_ptr_nxt;
                        r_out_dat  <= w_rd_dat;
                        r_out_last <= (w_ptr_nxt == r_len_m1);
                    end
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE) | r_s1_vld | r_s2_vld;
    assign err_drop  = r_err_drop;

endmodule
